// File: rtl/nu_layer_sequencer_pkg.sv
// Shared types and timing constants for the NU layer sequencer slice.
package nu_layer_sequencer_pkg;

    // Activation LUT geometry and the datapath latencies the sequencer aligns to.
    localparam int ACT_LUT_DEPTH = 256;
    localparam int ACT_LATENCY   = 2;
    localparam int MEM_LATENCY   = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/nu_layer_sequencer_delay.sv
// Fixed-depth shift register used to line strobes up with datapath latency.
module seq_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    // Shift one stage per cycle; reset flushes every stage so nothing in flight survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/nu_layer_sequencer.sv
// Sequences one fully-connected layer across the NU array: clear, MAC over the
// input vector, drain the memory pipeline, serialise lanes through the
// activation unit and write the results back to XY memory.
module nu_layer_sequencer
    import nu_layer_sequencer_pkg::*;
#(
    parameter int NU_COUNT    = 4,
    parameter int XY_DEPTH    = 12,
    parameter int W_DEPTH     = 12,
    parameter int MEM_LATENCY = nu_layer_sequencer_pkg::MEM_LATENCY,
    parameter int ACT_LATENCY = nu_layer_sequencer_pkg::ACT_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [XY_DEPTH-1:0]         cfg_in_count,
    input  logic [XY_DEPTH-1:0]         cfg_out_count,
    input  logic [XY_DEPTH-1:0]         cfg_x_base,
    input  logic [XY_DEPTH-1:0]         cfg_y_base,
    input  logic [W_DEPTH-1:0]          cfg_w_base,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err,
    output logic                        x_rd_en,
    output logic [XY_DEPTH-1:0]         x_rd_addr,
    output logic                        w_rd_en,
    output logic [W_DEPTH-1:0]          w_rd_addr,
    output logic                        nu_clear,
    output logic                        nu_mac_en,
    output logic [NU_COUNT-1:0]         nu_lane_mask,
    output logic [$clog2(NU_COUNT)-1:0] act_lane_sel,
    output logic                        act_valid,
    output logic                        y_wr_en,
    output logic [XY_DEPTH-1:0]         y_wr_addr
);

    // One extra bit so group_base never overflows, even for the largest out_count.
    localparam int CW = XY_DEPTH + 1;
    localparam int SW = $clog2(NU_COUNT);

    seq_state_t          state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       grp_base;
    logic [CW-1:0]       out_cnt;
    logic [XY_DEPTH-1:0] in_cnt;
    logic [XY_DEPTH-1:0] x_base;
    logic [XY_DEPTH-1:0] y_base;
    logic [W_DEPTH-1:0]  w_ptr;

    logic [CW-1:0]       rem;
    logic [CW-1:0]       lanes;
    logic [CW-1:0]       next_base;
    logic                last_grp;
    logic [XY_DEPTH:0]   wr_dly_in;

    // Lanes [0, r) carry real neurons; the rest of a partial group is masked off.
    function automatic logic [NU_COUNT-1:0] lane_mask(input logic [CW-1:0] r);
        logic [NU_COUNT-1:0] m;
        m = '0;
        for (int i = 0; i < NU_COUNT; i++) begin
            m[i] = (CW'(i) < r);
        end
        return m;
    endfunction

    // Group bookkeeping and the activation-side write address for the lane in flight.
    always_comb begin
        rem       = out_cnt - grp_base;
        lanes     = (rem > CW'(NU_COUNT)) ? CW'(NU_COUNT) : rem;
        next_base = grp_base + CW'(NU_COUNT);
        last_grp  = (next_base >= out_cnt);
        wr_dly_in = '0;
        if (act_valid) begin
            wr_dly_in = {1'b1, y_base + grp_base[XY_DEPTH-1:0] + XY_DEPTH'(act_lane_sel)};
        end
    end

    // Layer FSM; every strobe is registered so it is valid for the whole state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            grp_base     <= '0;
            out_cnt      <= '0;
            in_cnt       <= '0;
            x_base       <= '0;
            y_base       <= '0;
            w_ptr        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            x_rd_en      <= 1'b0;
            x_rd_addr    <= '0;
            w_rd_en      <= 1'b0;
            w_rd_addr    <= '0;
            nu_clear     <= 1'b0;
            nu_lane_mask <= '0;
            act_lane_sel <= '0;
            act_valid    <= 1'b0;
        end else begin
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            nu_clear  <= 1'b0;
            x_rd_en   <= 1'b0;
            w_rd_en   <= 1'b0;
            act_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_in_count == '0 || cfg_out_count == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            in_cnt       <= cfg_in_count;
                            out_cnt      <= {1'b0, cfg_out_count};
                            x_base       <= cfg_x_base;
                            y_base       <= cfg_y_base;
                            w_ptr        <= cfg_w_base;
                            grp_base     <= '0;
                            cnt          <= '0;
                            busy         <= 1'b1;
                            nu_clear     <= 1'b1;
                            nu_lane_mask <= lane_mask({1'b0, cfg_out_count});
                            state        <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    x_rd_en   <= 1'b1;
                    w_rd_en   <= 1'b1;
                    x_rd_addr <= x_base;
                    w_rd_addr <= w_ptr;
                    cnt       <= '0;
                    state     <= MAC;
                end
                MAC: begin
                    if (cnt + CW'(1) == CW'(in_cnt)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        x_rd_en   <= 1'b1;
                        w_rd_en   <= 1'b1;
                        x_rd_addr <= x_rd_addr + XY_DEPTH'(1);
                        w_rd_addr <= w_rd_addr + W_DEPTH'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(MEM_LATENCY - 1)) begin
                        cnt          <= '0;
                        act_valid    <= 1'b1;
                        act_lane_sel <= '0;
                        state        <= WRITE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WRITE: begin
                    if (cnt + CW'(1) == lanes) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt          <= cnt + CW'(1);
                        act_valid    <= 1'b1;
                        act_lane_sel <= act_lane_sel + SW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == CW'(ACT_LATENCY - 1)) begin
                        cnt          <= '0;
                        act_lane_sel <= '0;
                        w_ptr        <= w_ptr + W_DEPTH'(in_cnt);
                        grp_base     <= next_base;
                        if (last_grp) begin
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            nu_lane_mask <= '0;
                            state        <= DONE;
                        end else begin
                            nu_clear     <= 1'b1;
                            nu_lane_mask <= lane_mask(out_cnt - next_base);
                            state        <= CLEAR;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MAC enable follows the read strobe by the memory latency so data and strobe align.
    seq_delay_line #(
        .WIDTH (1),
        .DEPTH (MEM_LATENCY)
    ) u_mac_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (x_rd_en),
        .dout (nu_mac_en)
    );

    // Write strobe and address follow the activation input by the activation latency.
    seq_delay_line #(
        .WIDTH (XY_DEPTH + 1),
        .DEPTH (ACT_LATENCY)
    ) u_wr_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (wr_dly_in),
        .dout ({y_wr_en, y_wr_addr})
    );

endmodule

// File: tb/tb_nu_layer_sequencer.sv
// Directed bench for nu_layer_sequencer with a queue-based scoreboard for
// reads, writes and lane masks, plus cycle-accurate done/err timing checks.
module tb_nu_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] cfg_in_count = '0;
    logic [11:0] cfg_out_count = '0;
    logic [11:0] cfg_x_base = '0;
    logic [11:0] cfg_y_base = '0;
    logic [11:0] cfg_w_base = '0;
    logic        busy, done, cfg_err, x_rd_en, w_rd_en, nu_clear, nu_mac_en;
    logic        act_valid, y_wr_en;
    logic [11:0] x_rd_addr, w_rd_addr, y_wr_addr;
    logic [3:0]  nu_lane_mask;
    logic [1:0]  act_lane_sel;

    nu_layer_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_in_count  (cfg_in_count),
        .cfg_out_count (cfg_out_count),
        .cfg_x_base    (cfg_x_base),
        .cfg_y_base    (cfg_y_base),
        .cfg_w_base    (cfg_w_base),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .x_rd_en       (x_rd_en),
        .x_rd_addr     (x_rd_addr),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .nu_clear      (nu_clear),
        .nu_mac_en     (nu_mac_en),
        .nu_lane_mask  (nu_lane_mask),
        .act_lane_sel  (act_lane_sel),
        .act_valid     (act_valid),
        .y_wr_en       (y_wr_en),
        .y_wr_addr     (y_wr_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_done = 0;
    int exp_y = 0;
    int done_rel = -1;
    int err_rel = -1;
    int busy_cnt = 0;
    int err_cnt = 0;
    int ycnt = 0;
    bit done_seen = 0;
    logic prev_x = 1'b0;

    logic [11:0] xq[$];
    logic [11:0] wq[$];
    logic [11:0] yq[$];
    logic [3:0]  mq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{busy, done, cfg_err, x_rd_en, x_rd_addr, w_rd_en, w_rd_addr, nu_clear,
                 nu_mac_en, nu_lane_mask, act_lane_sel, act_valid, y_wr_en, y_wr_addr};
    endfunction

    // Reference model: push every expected mask, read and write, and the done cycle.
    task automatic model(input int in_n, input int out_n, input int xb, input int yb, input int wb);
        int wp;
        int d;
        int lanes;
        logic [3:0] m;
        wp = wb;
        d = 1;
        exp_y = 0;
        for (int g = 0; g * 4 < out_n; g++) begin
            lanes = (out_n - g * 4 > 4) ? 4 : out_n - g * 4;
            m = '0;
            for (int k = 0; k < lanes; k++) m[k] = 1'b1;
            mq.push_back(m);
            for (int i = 0; i < in_n; i++) begin
                xq.push_back(12'(xb + i));
                wq.push_back(12'(wp + i));
            end
            for (int k = 0; k < lanes; k++) yq.push_back(12'(yb + g * 4 + k));
            exp_y += lanes;
            wp += in_n;
            d += 1 + in_n + 1 + lanes + 2;
        end
        exp_done = d;
    endtask

    task automatic launch(input int in_n, input int out_n, input int xb, input int yb, input int wb);
        @(posedge clk);
        #1;
        cfg_in_count  = 12'(in_n);
        cfg_out_count = 12'(out_n);
        cfg_x_base    = 12'(xb);
        cfg_y_base    = 12'(yb);
        cfg_w_base    = 12'(wb);
        start     = 1'b1;
        start_cyc = cyc;
        done_seen = 0;
        done_rel  = -1;
        err_rel   = -1;
        busy_cnt  = 0;
        err_cnt   = 0;
        ycnt      = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done_seen; i++) @(posedge clk);
        #1;
        check("done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic finish_checks(input string tag);
        check({tag, "_done_cyc"}, done_rel, exp_done);
        check({tag, "_busy_cyc"}, busy_cnt, exp_done - 1);
        check({tag, "_y_count"}, ycnt, exp_y);
        check({tag, "_xq_left"}, xq.size(), 0);
        check({tag, "_wq_left"}, wq.size(), 0);
        check({tag, "_yq_left"}, yq.size(), 0);
        check({tag, "_mq_left"}, mq.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on every strobe, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [11:0] e;
        if (rst) begin
            prev_x = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (x_rd_en) begin
                if (xq.size() == 0 || wq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL x_extra: unexpected read x=%0h w=%0h", x_rd_addr, w_rd_addr);
                end else begin
                    e = xq.pop_front();
                    check("x_rd_addr", 32'(x_rd_addr), 32'(e));
                    e = wq.pop_front();
                    check("w_rd_addr", 32'(w_rd_addr), 32'(e));
                end
            end
            check("w_en_tracks_x", 32'(w_rd_en), 32'(x_rd_en));
            if (y_wr_en) begin
                ycnt++;
                if (yq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL y_extra: unexpected write addr=%0h", y_wr_addr);
                end else begin
                    e = yq.pop_front();
                    check("y_wr_addr", 32'(y_wr_addr), 32'(e));
                end
            end
            if (nu_clear) begin
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL clear_extra: unexpected clear mask=%0h", nu_lane_mask);
                end else begin
                    check("lane_mask", 32'(nu_lane_mask), 32'(mq.pop_front()));
                end
            end
            if (nu_mac_en || prev_x) check("mac_lag", 32'(nu_mac_en), 32'(prev_x));
            prev_x = x_rd_en;
            if (done) begin
                done_seen = 1;
                done_rel  = cyc - start_cyc;
                check("done_busy_low", 32'(busy), 32'd0);
            end
            if (cfg_err) begin
                err_cnt++;
                err_rel = cyc - start_cyc;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(any_out()), 32'd0);
        rst = 1'b0;

        // 1: two groups, second partial
        model(3, 6, 'h010, 'h100, 'h000);
        launch(3, 6, 'h010, 'h100, 'h000);
        wait_done(100);
        finish_checks("t1");
        check("t1_done_abs", done_rel, 21);

        // 2: single lane, single input
        model(1, 1, 'h020, 'h200, 'h000);
        launch(1, 1, 'h020, 'h200, 'h000);
        wait_done(50);
        finish_checks("t2");

        // 3: zero counts rejected
        launch(0, 5, 'h010, 'h100, 'h000);
        repeat (5) @(posedge clk);
        #1;
        check("t3_err_cyc", err_rel, 1);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_busy", busy_cnt, 0);
        check("t3_no_done", 32'(done_seen), 32'd0);
        launch(2, 0, 'h010, 'h100, 'h000);
        repeat (3) @(posedge clk);
        #1;
        check("t3b_err_cnt", err_cnt, 1);
        check("t3b_busy", busy_cnt, 0);

        // 4: start during MAC is ignored
        model(3, 6, 'h010, 'h100, 'h000);
        launch(3, 6, 'h010, 'h100, 'h000);
        repeat (2) @(posedge clk);
        #1;
        cfg_in_count  = 12'd1;
        cfg_out_count = 12'd1;
        cfg_x_base    = 12'h7;
        cfg_y_base    = 12'h9;
        cfg_w_base    = 12'h5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        finish_checks("t4");

        // 5: reset during WRITE of group 0 aborts with no writes
        model(3, 4, 'h030, 'h300, 'h040);
        launch(3, 4, 'h030, 'h300, 'h040);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_outs_zero", 32'(any_out()), 32'd0);
        rst = 1'b0;
        check("t5_xq_left", xq.size(), 0);
        check("t5_mq_left", mq.size(), 0);
        check("t5_yq_unwritten", yq.size(), 4);
        yq.delete();
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_writes", ycnt, 0);
        check("t5_no_done", 32'(done_seen), 32'd0);
        model(1, 1, 'h031, 'h310, 'h000);
        launch(1, 1, 'h031, 'h310, 'h000);
        wait_done(50);
        finish_checks("t5b");

        // 6: x address wrap
        model(4, 1, 'hFFE, 'h400, 'h000);
        launch(4, 1, 'hFFE, 'h400, 'h000);
        wait_done(50);
        finish_checks("t6");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
